laser500_scandoubler: RTL

- Converts the 15 kHz RGB stream from the VTL video generator into 31 kHz VGA-rate video by line doubling.
- Buffers each incoming line and replays it twice at double pixel rate; optionally dims the repeated line to give scanlines.
- Sits between the VTL chip video outputs (video_r/g/b, video_hs, video_vs) and the OSD overlay inputs.
- Replaces the current raw sync-combining path to VGA.

---
 rtl/laser500_scandoubler.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/laser500_scandoubler.sv
// laser500_scandoubler: line doubler taking 15 kHz VTL RGB to 31 kHz VGA rate.
// Ports: clk (2x pixel clock), reset (sync, active high), ce_in (input pixel
//   enable), r/g/b_in + hs_in/vs_in (15 kHz video, active-low syncs),
//   scanlines (dim odd output lines), r/g/b_out + hs_out/vs_out (31 kHz video).
module laser500_scandoubler #(
    parameter int COLOR_W      = 6,
    parameter int HCNT_W       = 10,
    parameter int MIN_LINE     = 64,
    parameter int LINE_DEFAULT = 944
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce_in,
    input  logic [COLOR_W-1:0] r_in,
    input  logic [COLOR_W-1:0] g_in,
    input  logic [COLOR_W-1:0] b_in,
    input  logic               hs_in,
    input  logic               vs_in,
    input  logic               scanlines,
    output logic [COLOR_W-1:0] r_out,
    output logic [COLOR_W-1:0] g_out,
    output logic [COLOR_W-1:0] b_out,
    output logic               hs_out,
    output logic               vs_out
);
    localparam int PIX_W = 3 * COLOR_W;
    localparam int DEPTH = 2 ** (HCNT_W + 1);
    localparam logic [HCNT_W-1:0] HMAX    = '1;
    localparam logic [HCNT_W-1:0] LEN_DEF = HCNT_W'(LINE_DEFAULT);
    localparam logic [HCNT_W-1:0] LEN_MIN = HCNT_W'(MIN_LINE);

    // Two banks of line storage, addressed as {bank, pixel}.
    logic [PIX_W-1:0] mem [DEPTH];

    logic [HCNT_W-1:0] in_hcnt;
    logic [HCNT_W-1:0] line_len;
    logic [HCNT_W-1:0] sync_cnt;
    logic [HCNT_W-1:0] sync_len;
    logic [HCNT_W-1:0] out_hcnt;
    logic              wr_bank;
    logic              hs_prev;
    logic              vs_smp;
    logic              odd_line;
    logic              blank;
    logic              dim;
    logic [PIX_W-1:0]  rd_pix;

    logic              hs_fall;
    logic              hs_rise;
    logic              wr_en;
    logic              wr_sel;
    logic [HCNT_W-1:0] wr_idx;
    logic [HCNT_W:0]   wr_addr;
    logic [HCNT_W:0]   rd_addr;
    logic              hs_act;

    assign hs_fall = ce_in & hs_prev & ~hs_in;
    assign hs_rise = ce_in & ~hs_prev & hs_in;

    // The sample on which hs_in falls is pixel 0 of the new line, so it
    // already lands in the freshly selected bank at address 0.
    assign wr_sel  = wr_bank ^ hs_fall;
    assign wr_idx  = hs_fall ? '0 : in_hcnt;
    assign wr_en   = ~reset & ce_in & (hs_fall | (in_hcnt != HMAX));
    assign wr_addr = {wr_sel, wr_idx};
    assign rd_addr = {~wr_bank, out_hcnt};
    assign hs_act  = out_hcnt < (sync_len >> 1);

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= {r_in, g_in, b_in};
        rd_pix <= mem[rd_addr];
    end

    // Input side: capture pixels, measure line length and sync width.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_hcnt  <= '0;
            wr_bank  <= 1'b0;
            line_len <= LEN_DEF;
            sync_cnt <= '0;
            sync_len <= '0;
            hs_prev  <= 1'b1;
            vs_smp   <= 1'b1;
        end else if (ce_in) begin
            hs_prev <= hs_in;
            vs_smp  <= vs_in;
            if (hs_fall) begin
                if (in_hcnt >= LEN_MIN)
                    line_len <= in_hcnt;
                in_hcnt  <= HCNT_W'(1);
                wr_bank  <= ~wr_bank;
                sync_cnt <= HCNT_W'(1);
            end else begin
                if (in_hcnt != HMAX)
                    in_hcnt <= in_hcnt + 1'b1;
                if (!hs_in)
                    sync_cnt <= sync_cnt + 1'b1;
            end
            if (hs_rise)
                sync_len <= sync_cnt;
        end
    end

    // Output side: replay the previous line twice per input line.
    // Flags are registered alongside the 1-clk buffer read.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_hcnt <= '0;
            odd_line <= 1'b0;
            hs_out   <= 1'b1;
            vs_out   <= 1'b1;
            blank    <= 1'b1;
            dim      <= 1'b0;
        end else begin
            if (hs_fall) begin
                out_hcnt <= '0;
                odd_line <= 1'b0;
            end else if (out_hcnt >= line_len - 1'b1) begin
                out_hcnt <= '0;
                odd_line <= ~odd_line;
            end else begin
                out_hcnt <= out_hcnt + 1'b1;
            end
            hs_out <= ~hs_act;
            blank  <= hs_act;
            dim    <= scanlines & odd_line;
            if (out_hcnt == '0)
                vs_out <= vs_smp;
        end
    end

    always_comb begin
        r_out = '0;
        g_out = '0;
        b_out = '0;
        if (!blank) begin
            r_out = rd_pix[PIX_W-1 -: COLOR_W] >> dim;
            g_out = rd_pix[2*COLOR_W-1 -: COLOR_W] >> dim;
            b_out = rd_pix[COLOR_W-1 -: COLOR_W] >> dim;
        end
    end

endmodule
